// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: parametrised NRD-read/1-write register file with optional write bypass
// and a per-register busy scoreboard used by decode to stall on pending operands.
module regfile_bypass_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec
);
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            wr_ok, sb_ok;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok    = wr_en && addr_ok(wr_addr);
  assign sb_ok    = sb_set && addr_ok(sb_addr);
  assign busy_vec = busy_q;

  always_comb begin
    rf_d = rf_q;
    if (wr_ok) rf_d[wr_addr] = wr_data;
  end

  // A newer producer's set wins over a retiring write to the same register; flush wins over both.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < NREG; r++)
      busy_d[r] = flush ? 1'b0 :
                  (sb_ok && int'(sb_addr) == r) ? 1'b1 :
                  (wr_ok && int'(wr_addr) == r) ? 1'b0 : busy_q[r];
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) rf_q[r] <= '0;
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          ok, hit;
    assign ra  = rd_addr[i*AW +: AW];
    assign ok  = addr_ok(ra);
    assign hit = (BYPASS != 0) && wr_en && (wr_addr == ra);
    assign rd_data[i*XLEN +: XLEN] = !ok ? '0 : hit ? wr_data : rf_q[ra];
    assign rd_busy[i] = ok && busy_q[ra] && !hit;
  end
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb_regfile_bypass_sb: directed vectors against a bypassing 32-entry file and a
// non-bypassing 20-entry file driven by the same inputs.
module tb_regfile_bypass_sb;
  logic        clk = 0, rst_n = 0;
  logic [9:0]  rd_addr = '0;
  logic        wr_en = 0, sb_set = 0, flush = 0;
  logic [4:0]  wr_addr = '0, sb_addr = '0;
  logic [31:0] wr_data = '0;
  logic [63:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [31:0] busy_vec_a;
  logic [19:0] busy_vec_b;
  int nvec = 0, nmis = 0;

  always #5 clk = ~clk;

  regfile_bypass_sb dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .flush(flush), .busy_vec(busy_vec_a));

  regfile_bypass_sb #(.NREG(20), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .sb_set(sb_set), .sb_addr(sb_addr),
    .flush(flush), .busy_vec(busy_vec_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 0; sb_set = 0; flush = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    #2;
    for (int r = 0; r < 32; r++) begin
      rd(5'(r), 5'(r));
      chk("rst_data_a", rd_data_a[31:0] | rd_data_a[63:32], 0);
      chk("rst_busy_a", 32'(rd_busy_a), 0);
      chk("rst_data_b", rd_data_b[31:0] | rd_data_b[63:32], 0);
    end
    chk("rst_bv_a", busy_vec_a, 0);
    chk("rst_bv_b", 32'(busy_vec_b), 0);
    @(negedge clk);
    rst_n = 1;
    step();

    wr(5, 32'hDEADBEEF); step();
    rd(5, 5);
    chk("x5_p0_a", rd_data_a[31:0], 32'hDEADBEEF);
    chk("x5_p1_a", rd_data_a[63:32], 32'hDEADBEEF);
    chk("x5_p0_b", rd_data_b[31:0], 32'hDEADBEEF);
    wr(0, 32'h1234); step();
    rd(0, 0);
    chk("x0_a", rd_data_a[31:0], 0);
    chk("x0_b", rd_data_b[63:32], 0);

    wr(7, 32'h11111111); step();
    wr(7, 32'hA5A5A5A5); rd(5, 7);
    chk("byp_a", rd_data_a[31:0], 32'hA5A5A5A5);
    chk("nobyp_b", rd_data_b[31:0], 32'h11111111);
    chk("byp_other_port", rd_data_a[63:32], 32'hDEADBEEF);
    step(); rd(5, 7);
    chk("x7_after_b", rd_data_b[31:0], 32'hA5A5A5A5);

    sb_set = 1; sb_addr = 3; step();
    rd(3, 3);
    chk("sb3_busy_a", 32'(rd_busy_a), 2'b11);
    chk("sb3_busy_b", 32'(rd_busy_b), 2'b11);
    chk("sb3_bv_a", busy_vec_a, 32'h8);
    wr(3, 32'h33); rd(2, 3);
    chk("wr3_busy_a", 32'(rd_busy_a), 0);
    chk("wr3_busy_b", 32'(rd_busy_b), 2'b01);
    chk("wr3_data_a", rd_data_a[31:0], 32'h33);
    step(); rd(2, 3);
    chk("x3_clr_bv_a", busy_vec_a, 0);
    chk("x3_clr_bv_b", 32'(busy_vec_b), 0);
    chk("x3_data_b", rd_data_b[31:0], 32'h33);

    sb_set = 1; sb_addr = 4; wr(4, 32'h44); step();
    chk("set_beats_wr_a", busy_vec_a, 32'h10);
    chk("set_beats_wr_b", 32'(busy_vec_b), 32'h10);
    flush = 1; sb_set = 1; sb_addr = 4; wr(6, 32'h66); step();
    chk("flush_bv_a", busy_vec_a, 0);
    chk("flush_bv_b", 32'(busy_vec_b), 0);
    rd(4, 6);
    chk("flush_wr_a", rd_data_a[31:0], 32'h66);
    chk("x4_a", rd_data_a[63:32], 32'h44);

    sb_set = 1; sb_addr = 0; step();
    chk("sb0_ignored", busy_vec_a, 0);
    sb_set = 1; sb_addr = 20; wr(20, 32'h2020); step();
    rd(20, 20);
    chk("x20_a", rd_data_a[31:0], 32'h2020);
    chk("x20_b", rd_data_b[31:0], 0);
    chk("sb20_bv_a", busy_vec_a, 32'h0010_0000);
    chk("sb20_bv_b", 32'(busy_vec_b), 0);
    wr(19, 32'h1919); step();
    rd(19, 19);
    chk("x19_b", rd_data_b[63:32], 32'h1919);

    wr(1, 32'h0101); sb_set = 1; sb_addr = 1; step();
    sb_set = 1; sb_addr = 2; step();
    chk("pre_rst_bv_b", 32'(busy_vec_b), 32'h6);
    rd(2, 1);
    chk("pre_rst_x1_a", rd_data_a[31:0], 32'h0101);
    rst_n = 0; #1;
    chk("mid_rst_bv_a", busy_vec_a, 0);
    chk("mid_rst_bv_b", 32'(busy_vec_b), 0);
    chk("mid_rst_x1_a", rd_data_a[31:0], 0);
    chk("mid_rst_busy_a", 32'(rd_busy_a), 0);
    rd(5, 5);
    chk("mid_rst_x5_b", rd_data_b[31:0], 0);
    rst_n = 1;
    wr(9, 32'h99); step();
    rd(9, 9);
    chk("post_rst_wr_a", rd_data_a[63:32], 32'h99);
    chk("post_rst_wr_b", rd_data_b[31:0], 32'h99);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
